// File: rtl/pixel_out_stage.sv
// -----------------------------------------------------------------------------
// pixel_out_stage
//
// Final stage of the pixel pipeline. It accepts processed pixels from upstream
// through a valid/ready handshake, buffers them in a small FIFO, and sends them
// out on a registered 8-bit bus to the downstream frame logger. The logger
// samples the bus on every clk.
//
// Frame sequencing:
//   IDLE   -- start pulse: clear the counters and the FIFO, then go to STREAM
//   STREAM -- accept pixels until IMG_W*IMG_H have been taken. Pop one FIFO
//             entry per clk whenever one is available. Leave on the edge that
//             emits the last pixel of the frame.
//   DONE   -- a single cycle. frame_done is high here. Return to IDLE.
//
// Parameters:
//   IMG_W, IMG_H  frame geometry (pixels per line, lines per frame)
//   FIFO_DEPTH    output FIFO entries; must be a power of two and >= 2
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rst         synchronous reset, active high; wins over every other input
//   start       one-cycle pulse; starts a frame when the block is in IDLE
//   in_pix      upstream pixel
//   in_valid    in_pix is valid
//   in_ready    the block accepts in_pix this cycle
//   bus_out     registered output pixel
//   out_valid   bus_out carries a frame pixel this cycle
//   frame_done  one-cycle pulse in the cycle after the last pixel is emitted
//   busy        high in STREAM and DONE
//
// Build option:
//   BUS_IDLE_HOLD_EN  when defined, bus_out keeps the last emitted pixel while
//                     out_valid is low. When not defined, bus_out is driven to
//                     zero in those cycles.
// -----------------------------------------------------------------------------
module pixel_out_stage #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_pix,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] bus_out,
    output logic       out_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] NPIX_C  = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]       state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ;
    logic [CNT_W-1:0] in_cnt, out_cnt;

    logic fifo_full, fifo_empty, push, pop, last_pop;

    assign fifo_full  = (occ == DEPTH_C);
    assign fifo_empty = (occ == '0);

    // When the FIFO is full, in_ready stays low even if a pop happens in the
    // same cycle. This keeps in_ready independent of the pop path.
    assign in_ready = (state == S_STREAM) && !fifo_full && (in_cnt < NPIX_C);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_STREAM) && !fifo_empty;
    assign last_pop = pop && (out_cnt == NPIX_C - CNT_ONE);

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    // Frame state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_STREAM;
                S_STREAM: if (last_pop) state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage. It is not reset: an entry is only read after a push has
    // written it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_pix;
    end

    // FIFO pointers, occupancy and frame counters. Push and pop can only
    // happen in STREAM, so the start clear below never races with them.
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            // Pointers are exactly PTR_W bits wide, so they wrap modulo the depth.
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase

            // in_cnt saturates because in_ready is low once it reaches NPIX.
            if (push) in_cnt <= in_cnt + CNT_ONE;
            if (pop && out_cnt < NPIX_C) out_cnt <= out_cnt + CNT_ONE;
        end
    end

    // Output register. A pixel popped at edge k+1 is on the bus right after
    // that edge. This gives one cycle of latency from a push into an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out   <= 8'd0;
            out_valid <= 1'b0;
        end else if (pop) begin
            bus_out   <= mem[rd_ptr];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
`ifdef BUS_IDLE_HOLD_EN
            bus_out   <= bus_out;
`else
            bus_out   <= 8'd0;
`endif
        end
    end

endmodule

// File: tb/tb_pixel_out_stage.sv
// -----------------------------------------------------------------------------
// tb_pixel_out_stage
//
// Scoreboard bench for pixel_out_stage, configured with a small frame
// (4x2 pixels) and a 4-entry FIFO.
//
// Stimulus:
//   A driver issues directed scenarios and then randomized frames.
//
// Reference model:
//   A behavioural model tracks the frame phase, a queue of accepted pixels
//   that have not yet been emitted, and the in/out pixel counts.
//
// Checking:
//   Each accepted pixel is pushed into the scoreboard queue. A monitor on the
//   falling edge compares every DUT output against the model for the current
//   cycle.
// -----------------------------------------------------------------------------
module tb_pixel_out_stage;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam int N = W * H;
`ifdef BUS_IDLE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_pix = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] bus_out;
    logic       out_valid;
    logic       frame_done;
    logic       busy;

    pixel_out_stage #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_pix     (in_pix),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bus_out    (bus_out),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Frame phases: 0 = waiting for start, 1 = frame in flight, 2 = the
    // single cycle after the last pixel has left.
    int         m_phase = 0;
    byte        sb[$];        // pixels accepted but not yet emitted
    int         m_taken = 0;  // pixels accepted in this frame
    int         m_sent  = 0;  // pixels emitted in this frame
    logic [7:0] e_bus = 8'd0;
    logic       e_ov  = 1'b0;
    logic [7:0] m_last = 8'd0;
    bit         chk_en = 1'b0;

    function automatic bit model_ready();
        return (m_phase == 1) && (sb.size() < D) && (m_taken < N);
    endfunction

    always @(negedge clk) begin
        bit acc;
        bit emitted;
        if (chk_en) begin
            chk("out_valid",  out_valid,  e_ov);
            chk("bus_out",    bus_out,    e_bus);
            chk("frame_done", frame_done, m_phase == 2);
            chk("busy",       busy,       m_phase != 0);
            chk("in_ready",   in_ready,   model_ready());
        end

        // Predict the outputs for the cycle after the next rising edge.
        acc = in_valid && model_ready();
        emitted = 1'b0;
        if (rst) begin
            m_phase = 0;
            sb.delete();
            m_taken = 0;
            m_sent  = 0;
            m_last  = 8'd0;
            chk_en  = 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                sb.delete();
                m_taken = 0;
                m_sent  = 0;
            end
        end else if (m_phase == 1) begin
            if (sb.size() > 0) begin
                m_last  = sb.pop_front();
                emitted = 1'b1;
                m_sent++;
            end
            if (acc) begin
                sb.push_back(in_pix);
                m_taken++;
            end
            if (emitted && m_sent == N) m_phase = 2;
        end else begin
            m_phase = 0;
        end

        if (rst) begin
            e_ov  = 1'b0;
            e_bus = 8'd0;
        end else if (emitted) begin
            e_ov  = 1'b1;
            e_bus = m_last;
        end else begin
            e_ov  = 1'b0;
            e_bus = HOLD ? m_last : 8'd0;
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] p);
        @(posedge clk);
        #1;
        rst = r;
        start = s;
        in_valid = v;
        in_pix = p;
    endtask

    // Run until the DUT drops busy, optionally offering random traffic and
    // occasional stray start pulses. An expired budget is reported as a failure.
    task automatic wait_idle(input int budget, input bit feed);
        int n = 0;
        while (busy && n < budget) begin
            if (feed)
                drive(1'b0, ($urandom % 8) == 0, $urandom % 2, 8'($urandom));
            else
                drive(1'b0, 1'b0, 1'b0, 8'd0);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL frame_timeout: busy still %0b after %0d cycles, need 0", busy, budget);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 1'b1, 8'h55);  // offered while idle: must be ignored

        // Basic frame with in_valid held high.
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < N; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
        wait_idle(40, 1'b0);

        // Burst: 28 pixels offered; only 8 may be taken.
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < N + 20; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h20 + i));
        wait_idle(40, 1'b0);

        // in_valid toggling every other cycle.
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 2 * N; i++) drive(1'b0, 1'b0, i[0] == 1'b0, 8'(8'h40 + i));
        wait_idle(40, 1'b0);

        // Reset after 3 accepted pixels, with valid still high. Then a full frame.
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h60 + i));
        drive(1'b1, 1'b0, 1'b1, 8'hAA);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < N; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h70 + i));
        wait_idle(40, 1'b0);

        // Reset and start asserted together: reset wins.
        drive(1'b1, 1'b1, 1'b1, 8'hBB);
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        // Start pulsed mid-frame must not clear anything.
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
        drive(1'b0, 1'b1, 1'b1, 8'h84);
        for (int i = 5; i < N + 4; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
        wait_idle(40, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, $urandom % 2, 8'($urandom));
            drive(1'b0, 1'b1, $urandom % 2, 8'($urandom));
            wait_idle(300, 1'b1);
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, limit 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_out_stage.md
PIXEL_OUT_STAGE -- requirements
Module: pixel_out_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  IMG_W, 64, pixels per line
  IMG_H, 64, lines per frame
  FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on rising edge
  rst  input  1  reset, synchronous, active-high
  start  input  1  one-cycle pulse that begins a frame
  in_pix  input  8  upstream processed pixel
  in_valid  input  1  in_pix valid
  in_ready  output  1  block accepts in_pix this cycle
  bus_out  output  8  registered output pixel, sampled by the downstream logger every clk
  out_valid  output  1  bus_out carries a frame pixel this cycle
  frame_done  output  1  one-cycle pulse after the last pixel is emitted
  busy  output  1  high in STREAM and DONE states

Function
REQ-003 The state machine SHALL have three states: IDLE, STREAM and DONE.
REQ-004 In IDLE, start=1 SHALL move the block to STREAM on the next edge.
  - Clears in_cnt, out_cnt and the FIFO.
  - start is ignored in STREAM and DONE.
REQ-005 A pixel is accepted on an edge where in_valid=1 and in_ready=1.
  - in_ready = (state==STREAM) AND FIFO not full AND in_cnt < IMG_W*IMG_H.
  - When in_ready=0 the block SHALL NOT consume data.
REQ-006 In STREAM, on each edge where the FIFO is non-empty, the block SHALL pop one entry into bus_out and set out_valid=1.
  - Otherwise out_valid=0.
REQ-007 Latency: a pixel pushed into an empty FIFO at edge k SHALL appear on bus_out, with out_valid=1, after edge k+1.
  - Throughput is one pixel per clk.
REQ-008 Push and pop in the same cycle SHALL both take effect; FIFO occupancy is unchanged.
REQ-009 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle. No full-bypass.
REQ-010 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL use a log2(FIFO_DEPTH)+1 bit count.
REQ-011 Counter widths: in_cnt and out_cnt SHALL be ceil(log2(IMG_W*IMG_H+1)) bits and SHALL saturate at IMG_W*IMG_H.
REQ-012 On the edge that emits pixel number IMG_W*IMG_H, the block SHALL move to DONE.
  - frame_done=1 during the following single cycle only.
REQ-013 DONE SHALL return to IDLE on the next edge.
REQ-014 Pixels SHALL be emitted in acceptance order, unmodified.

Reset
REQ-015 rst=1 at a rising edge SHALL force the block to a known state, regardless of the current state or a frame in progress:
  - state=IDLE
  - FIFO emptied
  - in_cnt=out_cnt=0
  - bus_out=8'd0, out_valid=0, frame_done=0, busy=0, in_ready=0
REQ-016 rst SHALL take priority over start, in_valid and pops in the same cycle.

Configuration
REQ-017 The macro BUS_IDLE_HOLD_EN SHALL select the value of bus_out when out_valid=0:
  - Defined: bus_out holds the last emitted pixel (0 after reset).
  - Not defined: bus_out is driven to 8'd0 whenever out_valid=0.
  - All other behaviour is identical in both builds.

Verification
REQ-018 Basic frame (IMG_W=4, IMG_H=2): rst pulse, start, then 8 pixels 0x10..0x17 with in_valid held high.
  - bus_out shows 0x10..0x17 on consecutive cycles, first one cycle after the first accept.
  - frame_done pulses exactly once, one cycle after 0x17.
REQ-019 Backpressure: FIFO_DEPTH=4, 8-pixel frame fed in a burst (20 more pixels offered).
  - in_ready falls while the FIFO is full.
  - No pixel is lost or duplicated.
  - Acceptance stops after exactly 8 pixels.
REQ-020 Gaps: in_valid toggles every other cycle.
  - out_valid toggles accordingly.
  - bus_out is 0x00 in gap cycles without BUS_IDLE_HOLD_EN, and the previous pixel with it.
REQ-021 Reset mid-frame: rst asserted after 3 of 8 pixels.
  - Next cycle: out_valid=0, busy=0, bus_out=0.
  - A new start and a full 8-pixel frame complete normally.
REQ-022 Ignored start: start pulsed while in STREAM.
  - No counter clear; the frame still ends after exactly IMG_W*IMG_H pixels.
